// File: rtl/key_click_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_click_decoder                                          |
// | Description : Groups debounced key presses that arrive within an         |
// |               inactivity window into one gesture. Each gesture is        |
// |               reported as a one-cycle event with a click count of 1..3.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module key_click_decoder #(
  parameter int WIN_CYCLES = 3600000,
  parameter int CNT_W      = 22,
  parameter int MAX_CLICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pulse,
  output logic       busy,
  output logic       event_valid,
  output logic [1:0] event_count,
  output logic       single_click,
  output logic       double_click,
  output logic       triple_click
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [1:0]       C_MAX    = 2'(MAX_CLICKS);
  localparam logic [CNT_W-1:0] C_T_LAST = CNT_W'(WIN_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_clicks;
  logic [CNT_W-1:0] r_timer;

  logic [1:0]       w_clicks_inc;
  logic             w_emit;
  logic [1:0]       w_emit_count;

  assign w_clicks_inc = r_clicks + 2'd1;

  // Decide whether the current cycle closes a gesture, and with which count.
  // A pulse always takes priority over a coincident timeout.
  always_comb begin
    w_emit       = 1'b0;
    w_emit_count = 2'd0;
    case (r_state)
      ST_IDLE: begin
        if (key_pulse && (C_MAX == 2'd1)) begin
          w_emit       = 1'b1;
          w_emit_count = 2'd1;
        end
      end
      ST_WAIT: begin
        if (key_pulse) begin
          if (w_clicks_inc == C_MAX) begin
            w_emit       = 1'b1;
            w_emit_count = C_MAX;
          end
        end else if (r_timer == C_T_LAST) begin
          w_emit       = 1'b1;
          w_emit_count = r_clicks;
        end
      end
      default: begin
        w_emit       = 1'b0;
        w_emit_count = 2'd0;
      end
    endcase
  end

  // Gesture FSM with registered event strobes and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_clicks     <= 2'd0;
      r_timer      <= '0;
      busy         <= 1'b0;
      event_valid  <= 1'b0;
      event_count  <= 2'd0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      triple_click <= 1'b0;
    end else begin
      event_valid  <= w_emit;
      event_count  <= w_emit_count;
      single_click <= w_emit && (w_emit_count == 2'd1);
      double_click <= w_emit && (w_emit_count == 2'd2);
      triple_click <= w_emit && (w_emit_count == 2'd3);

      case (r_state)
        ST_IDLE: begin
          // With MAX_CLICKS of 1 the press is reported directly from IDLE.
          if (key_pulse && (C_MAX != 2'd1)) begin
            r_state  <= ST_WAIT;
            r_clicks <= 2'd1;
            r_timer  <= '0;
            busy     <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (key_pulse) begin
            r_timer <= '0;
            if (w_emit) begin
              r_state  <= ST_IDLE;
              r_clicks <= 2'd0;
              busy     <= 1'b0;
            end else begin
              r_clicks <= w_clicks_inc;
            end
          end else if (w_emit) begin
            r_state  <= ST_IDLE;
            r_clicks <= 2'd0;
            r_timer  <= '0;
            busy     <= 1'b0;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_clicks <= 2'd0;
          r_timer  <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_click_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_key_click_decoder                                       |
// | Description : Scoreboard bench for key_click_decoder: directed gesture   |
// |               scenarios followed by random press trains, checked against |
// |               a press-time based gesture model.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_key_click_decoder;

  localparam int WIN = 16;
  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_pulse = 1'b0;
  logic       busy;
  logic       event_valid;
  logic [1:0] event_count;
  logic       single_click;
  logic       double_click;
  logic       triple_click;

  key_click_decoder #(
    .WIN_CYCLES (WIN),
    .CNT_W      (5),
    .MAX_CLICKS (MAXC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_pulse    (key_pulse),
    .busy         (busy),
    .event_valid  (event_valid),
    .event_count  (event_count),
    .single_click (single_click),
    .double_click (double_click),
    .triple_click (triple_click)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int cnt;
  } ev_t;

  ev_t ev_q[$];
  bit  busy_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int cur_cycle = -1;

  // Gesture model: open flag, presses so far, and cycle of the latest press.
  bit m_open = 1'b0;
  int m_cnt  = 0;
  int m_last = 0;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cur_cycle);
  endfunction

  function automatic void push_ev(int c, int cnt);
    ev_t e;
    e.due = c;
    e.cnt = cnt;
    ev_q.push_back(e);
  endfunction

  // Apply one cycle of stimulus and predict the outputs seen after the edge.
  task automatic step(input bit r, input bit p);
    @(negedge clk);
    cur_cycle++;
    rst       = r;
    key_pulse = p;
    if (r) begin
      m_open = 1'b0;
      m_cnt  = 0;
    end else if (!m_open) begin
      if (p) begin
        if (MAXC == 1) push_ev(cur_cycle, 1);
        else begin
          m_open = 1'b1;
          m_cnt  = 1;
          m_last = cur_cycle;
        end
      end
    end else if (p) begin
      m_cnt++;
      m_last = cur_cycle;
      if (m_cnt == MAXC) begin
        push_ev(cur_cycle, m_cnt);
        m_open = 1'b0;
      end
    end else if (cur_cycle - m_last == WIN) begin
      push_ev(cur_cycle, m_cnt);
      m_open = 1'b0;
    end
    busy_q.push_back(m_open);
  endtask

  // Directed scenario: reset for local cycles 0-2, pulses at listed local
  // cycles, optional reset at rst_at, total length len cycles.
  task automatic scenario(input int pulses[$], input int rst_at, input int len);
    for (int c = 0; c < len; c++) begin
      bit p = 1'b0;
      foreach (pulses[i]) if (pulses[i] == c) p = 1'b1;
      step((c < 3) || (c == rst_at), p);
    end
  endtask

  // Monitor: compare sampled outputs against the scoreboard queues.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy_q.size() != 0) begin
        bit b;
        b = busy_q.pop_front();
        chk("busy", int'(busy), int'(b));
        while (ev_q.size() != 0 && ev_q[0].due < cur_cycle) begin
          chk("missed_event_cnt", 0, ev_q[0].cnt);
          void'(ev_q.pop_front());
        end
        if (event_valid) begin
          if (ev_q.size() == 0 || ev_q[0].due != cur_cycle) begin
            chk("unexpected_event", int'(event_count), 0);
          end else begin
            ev_t e;
            e = ev_q.pop_front();
            chk("event_count", int'(event_count), e.cnt);
            chk("single_click", int'(single_click), int'(e.cnt == 1));
            chk("double_click", int'(double_click), int'(e.cnt == 2));
            chk("triple_click", int'(triple_click), int'(e.cnt == 3));
          end
        end else begin
          chk("idle_outputs", int'({event_count, single_click, double_click, triple_click}), 0);
        end
      end
    end
  end

  initial begin
    int gap;
    int q_single[$]   = '{10};
    int q_double[$]   = '{10, 20};
    int q_triple[$]   = '{10, 14, 18};
    int q_boundary[$] = '{10, 26};
    int q_b2b[$]      = '{10, 27};
    int q_rst[$]      = '{10, 15, 30};

    scenario(q_single,   -1, 40);
    scenario(q_double,   -1, 50);
    scenario(q_triple,   -1, 40);
    scenario(q_boundary, -1, 60);
    scenario(q_b2b,      -1, 60);
    scenario(q_rst,      20, 60);

    // Random press trains: gaps cluster around the window edge to stress the
    // pulse-versus-timeout tie, plus short gaps and multi-cycle highs.
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      bit r;
      bit p;
      r = ($urandom_range(0, 399) == 0);
      p = 1'b0;
      if (gap == 0) begin
        p = 1'b1;
        case ($urandom_range(0, 2))
          0:       gap = $urandom_range(0, 5);
          1:       gap = $urandom_range(WIN - 3, WIN + 1);
          default: gap = $urandom_range(WIN + 2, 2 * WIN + 8);
        endcase
      end else begin
        gap--;
      end
      step(r, p);
    end
    for (int c = 0; c < WIN + 4; c++) step(1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("leftover_events", ev_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
